// File: rtl/dmem_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dmem_pkg : shared types and constants for the data-memory controller |
// | Revision : 1.0                                                       |
// +--------------------------------------------------------------------+
package dmem_pkg;

  // RV64I load/store size codes; stores reuse LB/LH/LW/LD for SB/SH/SW/SD
  typedef enum logic [2:0] {
    LB  = 3'd0,
    LH  = 3'd1,
    LW  = 3'd2,
    LD  = 3'd3,
    LBU = 3'd4,
    LHU = 3'd5,
    LWU = 3'd6
  } funct3_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int unsigned BE_W = 8;

endpackage
`default_nettype wire

// File: rtl/dmem_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dmem_ctrl_if : MEM-stage request/response bus (rsp_oob only when    |
// |                DMEM_BOUNDS_EN is defined)                           |
// | Revision     : 1.0                                                  |
// +--------------------------------------------------------------------+
interface dmem_ctrl_if #(
  parameter int unsigned XLEN = 64
);
  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [2:0]      req_funct3;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            rsp_valid;
  logic [XLEN-1:0] rsp_rdata;
  logic            rsp_misaligned;
`ifdef DMEM_BOUNDS_EN
  logic            rsp_oob;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_misaligned, rsp_oob
  );
  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_misaligned, rsp_oob
  );
`else
  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_misaligned
  );
  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_misaligned
  );
`endif
endinterface
`default_nettype wire

// File: rtl/dmem_lane_align.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dmem_lane_align : byte-lane mask, store replication, load extract/  |
// |                   extend and alignment decode (combinational)       |
// | Revision        : 1.0                                               |
// +--------------------------------------------------------------------+
module dmem_lane_align
  import dmem_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic            we,
  input  logic [2:0]      funct3,
  input  logic [2:0]      byte_off,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rword,
  output logic [BE_W-1:0] be,
  output logic [XLEN-1:0] wdata_rep,
  output logic [XLEN-1:0] rdata_ext,
  output logic            misaligned
);

  logic [BE_W-1:0] base_mask;
  logic [XLEN-1:0] shifted;
  logic            illegal;
  logic            unaligned;

  always_comb begin
    base_mask = 8'h01;
    wdata_rep = {8{wdata[7:0]}};
    unaligned = 1'b0;
    // Stores only encode sizes 0..3; loads reserve 3'b111
    illegal   = we ? funct3[2] : (funct3 == 3'b111);
    case (funct3[1:0])
      2'd0: begin
        base_mask = 8'h01;
        wdata_rep = {8{wdata[7:0]}};
        unaligned = 1'b0;
      end
      2'd1: begin
        base_mask = 8'h03;
        wdata_rep = {4{wdata[15:0]}};
        unaligned = byte_off[0];
      end
      2'd2: begin
        base_mask = 8'h0F;
        wdata_rep = {2{wdata[31:0]}};
        unaligned = |byte_off[1:0];
      end
      default: begin
        base_mask = 8'hFF;
        wdata_rep = wdata;
        unaligned = |byte_off;
      end
    endcase
    be         = base_mask << byte_off;
    misaligned = illegal | unaligned;
  end

  always_comb begin
    shifted = rword >> {byte_off, 3'b000};
    case (funct3)
      LB:      rdata_ext = {{56{shifted[7]}},  shifted[7:0]};
      LH:      rdata_ext = {{48{shifted[15]}}, shifted[15:0]};
      LW:      rdata_ext = {{32{shifted[31]}}, shifted[31:0]};
      LD:      rdata_ext = shifted;
      LBU:     rdata_ext = {56'd0, shifted[7:0]};
      LHU:     rdata_ext = {48'd0, shifted[15:0]};
      LWU:     rdata_ext = {32'd0, shifted[31:0]};
      default: rdata_ext = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/dmem_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dmem_ctrl : RV64I data-memory controller with sub-word access,      |
// |             alignment faults and configurable read latency.         |
// |             Optional macro DMEM_BOUNDS_EN adds out-of-range faults. |
// | Revision  : 1.0                                                     |
// +--------------------------------------------------------------------+
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned XLEN   = 64,
  parameter int unsigned RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  dmem_ctrl_if.slave  bus,
  output logic        busy
);

  localparam int unsigned IDX    = $clog2(DEPTH);
  localparam logic [2:0]  LAT_M1 = 3'((RD_LAT == 0) ? 0 : RD_LAT - 1);

  logic [XLEN-1:0] mem_q [DEPTH];

  state_e          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [2:0]      funct3_q, funct3_d;
  logic            we_q, we_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            mis_q, mis_d;
  logic            valid_q, valid_d;
  logic            ready_q, ready_d;
  logic            busy_q, busy_d;

  logic            accept;
  logic            idle;
  logic [XLEN-1:0] sel_addr;
  logic [2:0]      sel_funct3;
  logic            sel_we;
  logic [IDX-1:0]  widx;
  logic [XLEN-1:0] rword;
  logic [BE_W-1:0] be;
  logic [XLEN-1:0] wdata_rep;
  logic [XLEN-1:0] ld_data;
  logic            misaligned;
  logic            oob;
  logic            fault;
  logic            wr_en;

  // In IDLE the live request drives the datapath so stores and zero-latency
  // loads complete on the accept edge; afterwards the latched copy is used.
  always_comb begin
    idle       = (state_q == IDLE);
    accept     = bus.req_valid && ready_q;
    sel_addr   = idle ? bus.req_addr   : addr_q;
    sel_funct3 = idle ? bus.req_funct3 : funct3_q;
    sel_we     = idle ? bus.req_we     : we_q;
    widx       = sel_addr[IDX+2:3];
    rword      = mem_q[widx];
  end

`ifdef DMEM_BOUNDS_EN
  logic oob_q, oob_d;
  assign oob = |sel_addr[XLEN-1:IDX+3];
`else
  logic unused_addr_hi;
  assign oob            = 1'b0;
  assign unused_addr_hi = ^sel_addr[XLEN-1:IDX+3];
`endif

  dmem_lane_align #(
    .XLEN (XLEN)
  ) u_lane_align (
    .we         (sel_we),
    .funct3     (sel_funct3),
    .byte_off   (sel_addr[2:0]),
    .wdata      (bus.req_wdata),
    .rword      (rword),
    .be         (be),
    .wdata_rep  (wdata_rep),
    .rdata_ext  (ld_data),
    .misaligned (misaligned)
  );

  assign fault = misaligned | oob;
  assign wr_en = accept && bus.req_we && !fault;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    funct3_d = funct3_q;
    we_d     = we_q;
    rdata_d  = rdata_q;
    mis_d    = mis_q;
`ifdef DMEM_BOUNDS_EN
    oob_d    = oob_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d   = bus.req_addr;
          funct3_d = bus.req_funct3;
          we_d     = bus.req_we;
          if (!bus.req_we && !fault && (RD_LAT != 0)) begin
            state_d = WAIT;
            cnt_d   = LAT_M1;
          end else begin
            state_d = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 3'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 3'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Sampling on RESP entry makes the earlier accept-edge store visible
    if ((state_d == RESP) && (state_q != RESP)) begin
      rdata_d = (sel_we || fault) ? '0 : ld_data;
      mis_d   = misaligned;
`ifdef DMEM_BOUNDS_EN
      oob_d   = oob;
`endif
    end

    valid_d = (state_d == RESP);
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 3'd0;
      addr_q   <= '0;
      funct3_q <= 3'd0;
      we_q     <= 1'b0;
      rdata_q  <= '0;
      mis_q    <= 1'b0;
      valid_q  <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      funct3_q <= funct3_d;
      we_q     <= we_d;
      rdata_q  <= rdata_d;
      mis_q    <= mis_d;
      valid_q  <= valid_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
    end
  end

`ifdef DMEM_BOUNDS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) oob_q <= 1'b0;
    else        oob_q <= oob_d;
  end
  assign bus.rsp_oob = oob_q;
`endif

  // RAM contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < BE_W; b++) begin
        if (be[b]) mem_q[widx][b*8 +: 8] <= wdata_rep[b*8 +: 8];
      end
    end
  end

  assign bus.req_ready      = ready_q;
  assign bus.rsp_valid      = valid_q;
  assign bus.rsp_rdata      = rdata_q;
  assign bus.rsp_misaligned = mis_q;
  assign busy               = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_dmem_ctrl : directed, table-driven bench for dmem_ctrl           |
// | Revision     : 1.0                                                  |
// +--------------------------------------------------------------------+
module tb_dmem_ctrl;
  import dmem_pkg::*;

  localparam int unsigned DEPTH  = 1024;
  localparam int unsigned RD_LAT = 1;

  typedef struct {
    bit          we;
    logic [2:0]  f3;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp_rdata;
    bit          exp_mis;
    bit          exp_oob;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t vecs[$];

  dmem_ctrl_if #(.XLEN(64)) bus ();

  dmem_ctrl #(
    .DEPTH  (DEPTH),
    .XLEN   (64),
    .RD_LAT (RD_LAT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input bit we, input logic [2:0] f3, input logic [63:0] addr,
                              input logic [63:0] wdata, input logic [63:0] exp_rdata,
                              input bit exp_mis, input bit exp_oob);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_mis = exp_mis; v.exp_oob = exp_oob;
    return v;
  endfunction

  task automatic do_req(input vec_t v, input int idx);
    int lat;
    bit got;
    int exp_lat;
    exp_lat = (v.we || v.exp_mis || v.exp_oob) ? 1 : RD_LAT + 1;
    for (int i = 0; i < 16 && !bus.req_ready; i++) begin
      @(posedge clk); #1;
    end
    check($sformatf("vec%0d_ready", idx), 64'(bus.req_ready), 64'd1);
    bus.req_valid  = 1'b1;
    bus.req_we     = v.we;
    bus.req_funct3 = v.f3;
    bus.req_addr   = v.addr;
    bus.req_wdata  = v.wdata;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 1;
    got = 1'b0;
    while (!got && lat <= 12) begin
      if (bus.rsp_valid) got = 1'b1;
      else begin
        @(posedge clk); #1;
        lat++;
      end
    end
    check($sformatf("vec%0d_rsp_seen", idx), 64'(got), 64'd1);
    if (got) begin
      check($sformatf("vec%0d_latency", idx), 64'(lat), 64'(exp_lat));
      check($sformatf("vec%0d_rdata", idx), bus.rsp_rdata, v.exp_rdata);
      check($sformatf("vec%0d_misaligned", idx), 64'(bus.rsp_misaligned), 64'(v.exp_mis));
`ifdef DMEM_BOUNDS_EN
      check($sformatf("vec%0d_oob", idx), 64'(bus.rsp_oob), 64'(v.exp_oob));
`endif
      @(posedge clk); #1;
      check($sformatf("vec%0d_pulse_end", idx), 64'(bus.rsp_valid), 64'd0);
    end
  endtask

  initial begin
    logic [63:0] bb_addr [3];
    logic [63:0] bb_exp  [3];
    int          acc     [3];
    int          k;
    int          n_rsp;
    bit          will;
    int          pulses;

    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;

    vecs.push_back(mk(1, LD,   64'h10, 64'h1122334455667788, 64'h0, 0, 0));
    vecs.push_back(mk(0, LD,   64'h10, 64'h0, 64'h1122334455667788, 0, 0));
    vecs.push_back(mk(1, LD,   64'h20, 64'h0, 64'h0, 0, 0));
    vecs.push_back(mk(1, LB,   64'h23, 64'hAAAAAAAAAAAAAAFF, 64'h0, 0, 0));
    vecs.push_back(mk(0, LB,   64'h23, 64'h0, 64'hFFFFFFFFFFFFFFFF, 0, 0));
    vecs.push_back(mk(0, LBU,  64'h23, 64'h0, 64'h00000000000000FF, 0, 0));
    vecs.push_back(mk(0, LD,   64'h20, 64'h0, 64'h00000000FF000000, 0, 0));
    vecs.push_back(mk(1, LB,   64'h20, 64'h7F, 64'h0, 0, 0));
    vecs.push_back(mk(0, LB,   64'h20, 64'h0, 64'h000000000000007F, 0, 0));
    vecs.push_back(mk(1, LD,   64'h28, 64'h0123456789ABCDEF, 64'h0, 0, 0));
    vecs.push_back(mk(1, LW,   64'h2C, 64'h0000000080000000, 64'h0, 0, 0));
    vecs.push_back(mk(0, LW,   64'h2C, 64'h0, 64'hFFFFFFFF80000000, 0, 0));
    vecs.push_back(mk(0, LWU,  64'h2C, 64'h0, 64'h0000000080000000, 0, 0));
    vecs.push_back(mk(0, LWU,  64'h28, 64'h0, 64'h0000000089ABCDEF, 0, 0));
    vecs.push_back(mk(0, LW,   64'h28, 64'h0, 64'hFFFFFFFF89ABCDEF, 0, 0));
    vecs.push_back(mk(1, LD,   64'h30, 64'hCAFEBABEDEADBEEF, 64'h0, 0, 0));
    vecs.push_back(mk(0, LH,   64'h31, 64'h0, 64'h0, 1, 0));
    vecs.push_back(mk(1, LD,   64'h34, 64'h5555555555555555, 64'h0, 1, 0));
    vecs.push_back(mk(0, LD,   64'h30, 64'h0, 64'hCAFEBABEDEADBEEF, 0, 0));
    vecs.push_back(mk(1, LH,   64'h36, 64'h0000000000001234, 64'h0, 0, 0));
    vecs.push_back(mk(0, LH,   64'h36, 64'h0, 64'h0000000000001234, 0, 0));
    vecs.push_back(mk(0, LH,   64'h32, 64'h0, 64'hFFFFFFFFFFFFDEAD, 0, 0));
    vecs.push_back(mk(0, LHU,  64'h32, 64'h0, 64'h000000000000DEAD, 0, 0));
    vecs.push_back(mk(0, 3'b111, 64'h30, 64'h0, 64'h0, 1, 0));
    vecs.push_back(mk(1, LBU,  64'h30, 64'h0, 64'h0, 1, 0));
    vecs.push_back(mk(0, LD,   64'h30, 64'h0, 64'h1234BABEDEADBEEF, 0, 0));
`ifdef DMEM_BOUNDS_EN
    vecs.push_back(mk(0, LD,   64'(DEPTH*8), 64'h0, 64'h0, 0, 1));
    vecs.push_back(mk(0, LH,   64'(DEPTH*8) + 64'h1, 64'h0, 64'h0, 1, 1));
    vecs.push_back(mk(1, LB,   64'(DEPTH*8) + 64'h37, 64'h56, 64'h0, 0, 1));
    vecs.push_back(mk(0, LD,   64'h30, 64'h0, 64'h1234BABEDEADBEEF, 0, 0));
`else
    vecs.push_back(mk(0, LD,   64'(DEPTH*8) + 64'h30, 64'h0, 64'h1234BABEDEADBEEF, 0, 0));
    vecs.push_back(mk(1, LB,   64'(DEPTH*8) + 64'h37, 64'h56, 64'h0, 0, 0));
    vecs.push_back(mk(0, LD,   64'h30, 64'h0, 64'h5634BABEDEADBEEF, 0, 0));
`endif

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", 64'(bus.req_ready), 64'd1);
    check("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("reset_rdata", bus.rsp_rdata, 64'd0);
    check("reset_misaligned", 64'(bus.rsp_misaligned), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
`ifdef DMEM_BOUNDS_EN
    check("reset_oob", 64'(bus.rsp_oob), 64'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) do_req(vecs[i], i);

    // Back-to-back loads with req_valid held high
    bb_addr[0] = 64'h10; bb_exp[0] = 64'h1122334455667788;
    bb_addr[1] = 64'h20; bb_exp[1] = 64'h00000000FF00007F;
    bb_addr[2] = 64'h28; bb_exp[2] = 64'h8000000089ABCDEF;
    acc[0] = 0; acc[1] = 0; acc[2] = 0;
    k = 0;
    n_rsp = 0;
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b0;
    bus.req_funct3 = LD;
    bus.req_addr   = bb_addr[0];
    for (int c = 0; c < 40 && n_rsp < 3; c++) begin
      if (bus.rsp_valid) begin
        check($sformatf("b2b_rdata%0d", n_rsp), bus.rsp_rdata, bb_exp[n_rsp]);
        n_rsp++;
      end
      will = bus.req_valid && bus.req_ready;
      @(posedge clk); #1;
      if (will && k < 3) begin
        acc[k] = c;
        k++;
        if (k < 3) bus.req_addr = bb_addr[k];
        else       bus.req_valid = 1'b0;
      end
    end
    bus.req_valid = 1'b0;
    check("b2b_accepts", 64'(k), 64'd3);
    check("b2b_responses", 64'(n_rsp), 64'd3);
    check("b2b_spacing01", 64'(acc[1] - acc[0]), 64'(RD_LAT + 2));
    check("b2b_spacing12", 64'(acc[2] - acc[1]), 64'(RD_LAT + 2));
    @(posedge clk); #1;

    // Reset while a load waits
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b0;
    bus.req_funct3 = LD;
    bus.req_addr   = 64'h10;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check("wait_busy", 64'(busy), 64'd1);
    check("wait_ready", 64'(bus.req_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    check("midrst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("midrst_ready", 64'(bus.req_ready), 64'd1);
    check("midrst_busy", 64'(busy), 64'd0);
    #2;
    rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (bus.rsp_valid) pulses++;
    end
    check("midrst_dropped", 64'(pulses), 64'd0);

    // Store survives a reset right after its accept edge
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = LD;
    bus.req_addr   = 64'h40;
    bus.req_wdata  = 64'h000000000000ABCD;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_req(mk(0, LD, 64'h40, 64'h0, 64'h000000000000ABCD, 0, 0), 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
